// File: rtl/hazard_controller.sv
// Decode-side hazard unit: load-use bubbles, redirect flush, panic drain/halt.
// Owns the ID/EX stall, front-end flush, halt state and a stall-cycle counter.
module hazard_controller #(
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [4:0]         id_reg_rs1,
    input  logic [4:0]         id_reg_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [4:0]         id_reg_rd,
    input  logic               id_load_word_memory,
    input  logic               id_panic,
    input  logic               ex_redirect,
    output logic               out_stall,
    output logic               out_flush,
    output logic               out_halt,
    output logic [1:0]         out_state,
    output logic [COUNT_W-1:0] out_stall_count
);

    localparam int CMAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [CW-1:0]                 cnt;
    logic [CW-1:0]                 cnt_next;
    logic [LOAD_LATENCY-1:0]       sb_valid;
    logic [LOAD_LATENCY-1:0][4:0]  sb_rd;
    logic                          hz;
    logic                          issue;

    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < LOAD_LATENCY; i++) begin
            if (sb_valid[i]) begin
                if (id_uses_rs1 && id_reg_rs1 != 5'd0 && sb_rd[i] == id_reg_rs1)
                    hz = 1'b1;
                if (id_uses_rs2 && id_reg_rs2 != 5'd0 && sb_rd[i] == id_reg_rs2)
                    hz = 1'b1;
            end
        end
    end

    // Reset masks the control outputs in the same cycle it is asserted
    always_comb begin
        out_stall = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN:         out_stall = id_valid & hz & ~ex_redirect;
                FLUSH:       out_stall = 1'b0;
                DRAIN, HALT: out_stall = 1'b1;
                default:     out_stall = 1'b0;
            endcase
        end
    end

    assign out_flush = ~reset & (ex_redirect | (state == FLUSH));
    assign out_halt  = (state == HALT);
    assign out_state = state;
    assign issue     = id_valid & ~out_stall & ~ex_redirect & (state == RUN);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RUN: begin
                if (ex_redirect) begin
                    state_next = FLUSH;
                    cnt_next   = CW'(FLUSH_CYCLES - 1);
                end else if (issue && id_panic) begin
                    state_next = DRAIN;
                    cnt_next   = CW'(DRAIN_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (ex_redirect) begin
                    cnt_next = CW'(FLUSH_CYCLES - 1);
                end else if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == '0) state_next = HALT;
                else           cnt_next   = cnt - CW'(1);
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            cnt             <= '0;
            sb_valid        <= '0;
            sb_rd           <= '0;
            out_stall_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= issue & id_load_word_memory & (id_reg_rd != 5'd0);
            sb_rd[0]    <= id_reg_rd;
            if (out_stall && out_stall_count != '1)
                out_stall_count <= out_stall_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: three instances with different
// load latency and counter width share one stimulus stream.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, load, panic, redirect;

    logic        stall_a, flush_a, halt_a;
    logic [1:0]  state_a;
    logic [15:0] count_a;
    logic        stall_b, flush_b, halt_b;
    logic [1:0]  state_b;
    logic [15:0] count_b;
    logic        stall_c, flush_c, halt_c;
    logic [1:0]  state_c;
    logic [3:0]  count_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_controller dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_reg_rs1(rs1), .id_reg_rs2(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .id_reg_rd(rd), .id_load_word_memory(load),
        .id_panic(panic), .ex_redirect(redirect),
        .out_stall(stall_a), .out_flush(flush_a), .out_halt(halt_a),
        .out_state(state_a), .out_stall_count(count_a)
    );

    hazard_controller #(.LOAD_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_reg_rs1(rs1), .id_reg_rs2(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .id_reg_rd(rd), .id_load_word_memory(load),
        .id_panic(panic), .ex_redirect(redirect),
        .out_stall(stall_b), .out_flush(flush_b), .out_halt(halt_b),
        .out_state(state_b), .out_stall_count(count_b)
    );

    hazard_controller #(.COUNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_reg_rs1(rs1), .id_reg_rs2(rs2),
        .id_uses_rs1(use1), .id_uses_rs2(use2),
        .id_reg_rd(rd), .id_load_word_memory(load),
        .id_panic(panic), .ex_redirect(redirect),
        .out_stall(stall_c), .out_flush(flush_c), .out_halt(halt_c),
        .out_state(state_c), .out_stall_count(count_c)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        id_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        use1 = 0; use2 = 0; load = 0; panic = 0; redirect = 0;
    endtask

    task automatic do_reset;
        set_idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++;
        if (state_a !== 2'd0) begin
            failures++; $display("FAIL rst_state got=%0d exp=0", state_a);
        end
        checks++;
        if ({stall_a, flush_a, halt_a} !== 3'b000) begin
            failures++; $display("FAIL rst_ctl got=%b exp=000", {stall_a, flush_a, halt_a});
        end
        checks++;
        if (count_a !== 16'd0) begin
            failures++; $display("FAIL rst_count got=%0d exp=0", count_a);
        end
    endtask

    task automatic test_load_use;
        do_reset();
        id_valid = 1; load = 1; rd = 5; rs1 = 1; use1 = 1;
        #1;
        checks++;
        if (stall_a !== 1'b0) begin
            failures++; $display("FAIL lu_lw_stall got=%0b exp=0", stall_a);
        end
        step();
        load = 0; rd = 6; rs1 = 5; rs2 = 1; use2 = 1;
        #1;
        checks++;
        if (stall_a !== 1'b1) begin
            failures++; $display("FAIL lu_bubble got=%0b exp=1", stall_a);
        end
        step();
        #1;
        checks++;
        if (stall_a !== 1'b0) begin
            failures++; $display("FAIL lu_release got=%0b exp=0", stall_a);
        end
        step();
        set_idle();
        #1;
        checks++;
        if (count_a !== 16'd1) begin
            failures++; $display("FAIL lu_count got=%0d exp=1", count_a);
        end
    endtask

    task automatic test_latency3;
        do_reset();
        id_valid = 1; load = 1; rd = 7; rs1 = 2; use1 = 1;
        step();
        load = 0; rd = 0; rs1 = 2; rs2 = 7; use2 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_b !== 1'b1) begin
                failures++; $display("FAIL l3_stall%0d got=%0b exp=1", i, stall_b);
            end
            step();
        end
        #1;
        checks++;
        if (stall_b !== 1'b0) begin
            failures++; $display("FAIL l3_release got=%0b exp=0", stall_b);
        end
        step();
        load = 1; rd = 0; rs1 = 3; rs2 = 0; use2 = 0;
        step();
        load = 0; rs1 = 2; rs2 = 0; use2 = 1;
        #1;
        checks++;
        if (stall_b !== 1'b0) begin
            failures++; $display("FAIL l3_x0 got=%0b exp=0", stall_b);
        end
        step();
        set_idle();
        #1;
        checks++;
        if (count_b !== 16'd3) begin
            failures++; $display("FAIL l3_count got=%0d exp=3", count_b);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        id_valid = 1; load = 1; rd = 5; rs1 = 1; use1 = 1;
        step();
        rd = 9; rs1 = 5; redirect = 1;
        #1;
        checks++;
        if ({stall_a, flush_a, state_a} !== 4'b0100) begin
            failures++;
            $display("FAIL rd_cycle0 got=%b exp=0100", {stall_a, flush_a, state_a});
        end
        checks++;
        if (stall_b !== 1'b0) begin
            failures++; $display("FAIL rd_b_stall got=%0b exp=0", stall_b);
        end
        step();
        redirect = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({stall_a, flush_a, state_a} !== 4'b0101) begin
                failures++;
                $display("FAIL rd_flush%0d got=%b exp=0101", i, {stall_a, flush_a, state_a});
            end
            step();
        end
        load = 0; rd = 10; rs1 = 9;
        #1;
        checks++;
        if ({flush_a, state_a} !== 3'b000) begin
            failures++; $display("FAIL rd_back_run got=%b exp=000", {flush_a, state_a});
        end
        checks++;
        if (stall_b !== 1'b0) begin
            failures++; $display("FAIL rd_no_insert got=%0b exp=0", stall_b);
        end
        step();
        set_idle();
    endtask

    task automatic test_panic;
        do_reset();
        id_valid = 1; panic = 1;
        #1;
        checks++;
        if ({stall_a, state_a} !== 3'b000) begin
            failures++; $display("FAIL pn_issue got=%b exp=000", {stall_a, state_a});
        end
        step();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            redirect = (i == 1);
            #1;
            checks++;
            if ({stall_a, halt_a, state_a} !== 4'b1010) begin
                failures++;
                $display("FAIL pn_drain%0d got=%b exp=1010", i, {stall_a, halt_a, state_a});
            end
            step();
        end
        redirect = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({stall_a, halt_a, state_a} !== 4'b1111) begin
                failures++;
                $display("FAIL pn_halt%0d got=%b exp=1111", i, {stall_a, halt_a, state_a});
            end
            step();
        end
        repeat (20) step();
        checks++;
        if (count_c !== 4'd15) begin
            failures++; $display("FAIL cnt_sat got=%0d exp=15", count_c);
        end
        checks++;
        if (count_a !== 16'd26) begin
            failures++; $display("FAIL cnt_wide got=%0d exp=26", count_a);
        end
        checks++;
        if (state_a !== 2'd3) begin
            failures++; $display("FAIL pn_sticky got=%0d exp=3", state_a);
        end
    endtask

    task automatic test_panic_redirect;
        do_reset();
        id_valid = 1; panic = 1; redirect = 1;
        #1;
        checks++;
        if ({stall_a, flush_a} !== 2'b01) begin
            failures++; $display("FAIL pr_ctl got=%b exp=01", {stall_a, flush_a});
        end
        step();
        set_idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (state_a !== 2'd1) begin
                failures++; $display("FAIL pr_flush%0d got=%0d exp=1", i, state_a);
            end
            step();
        end
        #1;
        checks++;
        if (state_a !== 2'd0) begin
            failures++; $display("FAIL pr_run got=%0d exp=0", state_a);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        id_valid = 1; panic = 1;
        step();
        set_idle();
        repeat (3) step();
        #1;
        checks++;
        if (halt_a !== 1'b1) begin
            failures++; $display("FAIL rm_halted got=%0b exp=1", halt_a);
        end
        reset = 1; id_valid = 1; redirect = 1;
        #1;
        checks++;
        if ({stall_a, flush_a} !== 2'b00) begin
            failures++; $display("FAIL rm_rst_cycle got=%b exp=00", {stall_a, flush_a});
        end
        step();
        reset = 0; set_idle();
        #1;
        checks++;
        if ({stall_a, flush_a, halt_a, state_a, count_a} !== 21'd0) begin
            failures++;
            $display("FAIL rm_cleared got=%b%b%b st=%0d cnt=%0d exp=all0",
                     stall_a, flush_a, halt_a, state_a, count_a);
        end
        id_valid = 1; load = 1; rd = 7;
        step();
        reset = 1; load = 0; rd = 8; rs2 = 7; use2 = 1;
        #1;
        checks++;
        if (stall_b !== 1'b0) begin
            failures++; $display("FAIL rm_sb_rst_cycle got=%0b exp=0", stall_b);
        end
        step();
        reset = 0;
        #1;
        checks++;
        if (stall_b !== 1'b0) begin
            failures++; $display("FAIL rm_sb_cleared got=%0b exp=0", stall_b);
        end
        step();
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1;
        test_reset();
        test_load_use();
        test_latency3();
        test_redirect();
        test_panic();
        test_panic_redirect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
